sas_predictor: RTL and testbench

SAS_PREDICTOR -- requirements
Module: sas_predictor

---
 rtl/sas_predictor.sv | 180 ++++++++++++++++++
 tb/tb_sas_predictor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sas_predictor.sv
// rtl/sas_predictor.sv - per-set (SAs) / global (GAs) two-level branch direction predictor
module sas_predictor #(
    parameter int FETCH_WIDTH   = 2,
    parameter int UPDATE_WIDTH  = 2,
    parameter int ADDR_BITS     = 32,
    parameter int HIST_BITS     = 4,
    parameter int PHT_ADDR_BITS = 10,
    parameter int CTR_BITS      = 2,
    parameter int SET_BITS      = 2,
    parameter int SET_SHIFT     = 10,
    parameter int MODE          = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             predReq,
    input  logic [ADDR_BITS-1:0]             predPC,
    input  logic [FETCH_WIDTH-1:0]           predCondMask,
    input  logic                             stall,
    output logic                             predValid,
    output logic [FETCH_WIDTH-1:0]           predTaken,
    output logic [FETCH_WIDTH*CTR_BITS-1:0]  predCtr,
    output logic [HIST_BITS-1:0]             predHist,
    input  logic [UPDATE_WIDTH-1:0]          updValid,
    input  logic [UPDATE_WIDTH-1:0]          updTaken,
    input  logic [UPDATE_WIDTH-1:0]          updMispred,
    input  logic [UPDATE_WIDTH-1:0]          updIsCond,
    input  logic [UPDATE_WIDTH*ADDR_BITS-1:0] updAddr,
    input  logic [UPDATE_WIDTH*HIST_BITS-1:0] updHist,
    input  logic [UPDATE_WIDTH*CTR_BITS-1:0]  updPrevCtr,
    output logic                             initBusy
);
    localparam int NUM_SETS = 1 << SET_BITS;
    localparam int PHT_SIZE = 1 << PHT_ADDR_BITS;
    localparam int LOW_BITS = PHT_ADDR_BITS - HIST_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1 << (CTR_BITS - 1));

    typedef enum logic {INIT, READY} stateE;

    stateE                    state, stateNext;
    logic [PHT_ADDR_BITS-1:0] initIndex;
    logic [HIST_BITS-1:0]     histReg [NUM_SETS];
    logic [CTR_BITS-1:0]      pht [PHT_SIZE];

    function automatic logic [SET_BITS-1:0] setOf(input logic [ADDR_BITS-1:0] a);
        if (MODE == 1) return a[SET_SHIFT +: SET_BITS];
        return '0;
    endfunction

    function automatic logic [PHT_ADDR_BITS-1:0] idxOf(input logic [HIST_BITS-1:0] h,
                                                       input logic [ADDR_BITS-1:0] a);
        return {h, a[2 +: LOW_BITS]};
    endfunction

    function automatic logic [CTR_BITS-1:0] nextCtr(input logic [CTR_BITS-1:0] c, input logic t);
        if (t) return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
        return (c == '0) ? c : c - CTR_BITS'(1);
    endfunction

    // Init FSM: sweep every PHT entry to weakly-taken before accepting traffic
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= INIT;
            initIndex <= '0;
        end else begin
            state <= stateNext;
            if (state == INIT) initIndex <= initIndex + 1'b1;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            INIT:    if (initIndex == '1) stateNext = READY;
            READY:   stateNext = READY;
            default: stateNext = INIT;
        endcase
    end

    assign initBusy = (state == INIT);

    logic                            accept;
    logic [SET_BITS-1:0]             predSet;
    logic [HIST_BITS-1:0]            curHist, specHist;
    logic [FETCH_WIDTH-1:0]          slotTaken;
    logic [FETCH_WIDTH*CTR_BITS-1:0] slotCtr;
    logic [ADDR_BITS-1:0]            slotAddr;
    logic [CTR_BITS-1:0]             ctr;
    logic                            stop;

    assign accept = predReq && !stall && (state == READY);

    // All slots index with the pre-update history; speculative shifts stop at the first taken slot
    always_comb begin
        predSet   = setOf(predPC);
        curHist   = histReg[predSet];
        specHist  = curHist;
        slotTaken = '0;
        slotCtr   = '0;
        slotAddr  = '0;
        ctr       = '0;
        stop      = 1'b0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            slotAddr = predPC + ADDR_BITS'(4 * i);
            ctr      = pht[idxOf(curHist, slotAddr)];
            slotCtr[i*CTR_BITS +: CTR_BITS] = ctr;
            if (predCondMask[i] && !stop) begin
                slotTaken[i] = ctr[CTR_BITS-1];
                specHist     = {specHist[HIST_BITS-2:0], ctr[CTR_BITS-1]};
                stop         = ctr[CTR_BITS-1];
            end
        end
    end

    logic [NUM_SETS-1:0]  recValid;
    logic [HIST_BITS-1:0] recHist [NUM_SETS];
    logic [SET_BITS-1:0]  recSet;
    logic [HIST_BITS-1:0] recBase;

    // Walk ports high to low so the lowest-numbered mispredict lands last per set
    always_comb begin
        recValid = '0;
        recSet   = '0;
        recBase  = '0;
        for (int s = 0; s < NUM_SETS; s++) recHist[s] = '0;
        for (int j = UPDATE_WIDTH - 1; j >= 0; j--) begin
            if (updValid[j] && updMispred[j]) begin
                recSet           = setOf(updAddr[j*ADDR_BITS +: ADDR_BITS]);
                recBase          = updHist[j*HIST_BITS +: HIST_BITS];
                recValid[recSet] = 1'b1;
                recHist[recSet]  = updIsCond[j] ? {recBase[HIST_BITS-2:0], updTaken[j]} : recBase;
            end
        end
    end

    // Backend recovery still lands while fetch is stalled; only the speculative shift is frozen
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NUM_SETS; s++) histReg[s] <= '0;
        end else if (state == READY) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                if (recValid[s])                                histReg[s] <= recHist[s];
                else if (accept && (SET_BITS'(s) == predSet))   histReg[s] <= specHist;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            predValid <= 1'b0;
            predTaken <= '0;
            predCtr   <= '0;
            predHist  <= '0;
        end else if (!stall) begin
            predValid <= accept;
            if (accept) begin
                predTaken <= slotTaken;
                predCtr   <= slotCtr;
                predHist  <= curHist;
            end
        end
    end

    // Later ports overwrite earlier ones on the same entry
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            pht[initIndex] <= CTR_INIT;
        end else begin
            for (int j = 0; j < UPDATE_WIDTH; j++) begin
                if (updValid[j])
                    pht[idxOf(updHist[j*HIST_BITS +: HIST_BITS], updAddr[j*ADDR_BITS +: ADDR_BITS])]
                        <= nextCtr(updPrevCtr[j*CTR_BITS +: CTR_BITS], updTaken[j]);
            end
        end
    end

    logic unusedBits;
    assign unusedBits = ^{predPC, updAddr, slotAddr};

endmodule

// File: tb/tb_sas_predictor.sv
// tb/tb_sas_predictor.sv - directed self-checking bench for sas_predictor
module tb_sas_predictor;
    localparam int FW = 2, UW = 2, AB = 32, HB = 4, CB = 2;

    logic clk = 1'b0;
    logic rst;
    logic predReq, stall;
    logic [AB-1:0] predPC;
    logic [FW-1:0] predCondMask;
    logic predValid, predValidG;
    logic [FW-1:0] predTaken, predTakenG;
    logic [FW*CB-1:0] predCtr, predCtrG;
    logic [HB-1:0] predHist, predHistG;
    logic [UW-1:0] updValid, updTaken, updMispred, updIsCond;
    logic [UW*AB-1:0] updAddr;
    logic [UW*HB-1:0] updHist;
    logic [UW*CB-1:0] updPrevCtr;
    logic initBusy, initBusyG;
    int tests = 0;
    int fails = 0;
    int cnt;

    always #5 clk = ~clk;

    sas_predictor #(.MODE(1)) dut (
        .clk(clk), .rst(rst), .predReq(predReq), .predPC(predPC), .predCondMask(predCondMask),
        .stall(stall), .predValid(predValid), .predTaken(predTaken), .predCtr(predCtr),
        .predHist(predHist), .updValid(updValid), .updTaken(updTaken), .updMispred(updMispred),
        .updIsCond(updIsCond), .updAddr(updAddr), .updHist(updHist), .updPrevCtr(updPrevCtr),
        .initBusy(initBusy)
    );

    sas_predictor #(.MODE(0)) dutG (
        .clk(clk), .rst(rst), .predReq(predReq), .predPC(predPC), .predCondMask(predCondMask),
        .stall(stall), .predValid(predValidG), .predTaken(predTakenG), .predCtr(predCtrG),
        .predHist(predHistG), .updValid(updValid), .updTaken(updTaken), .updMispred(updMispred),
        .updIsCond(updIsCond), .updAddr(updAddr), .updHist(updHist), .updPrevCtr(updPrevCtr),
        .initBusy(initBusyG)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearUpd();
        updValid = '0; updTaken = '0; updMispred = '0; updIsCond = '0;
        updAddr = '0; updHist = '0; updPrevCtr = '0;
    endtask

    task automatic setUpd(input int p, input logic [AB-1:0] a, input logic [HB-1:0] h,
                          input logic [CB-1:0] prev, input logic t, input logic mis, input logic cond);
        updValid[p]             = 1'b1;
        updAddr[p*AB +: AB]     = a;
        updHist[p*HB +: HB]     = h;
        updPrevCtr[p*CB +: CB]  = prev;
        updTaken[p]             = t;
        updMispred[p]           = mis;
        updIsCond[p]            = cond;
    endtask

    task automatic doUpd();
        step();
        clearUpd();
    endtask

    task automatic doPred(input logic [AB-1:0] pc, input logic [FW-1:0] mask);
        predReq = 1'b1; predPC = pc; predCondMask = mask;
        step();
        predReq = 1'b0;
        clearUpd();
    endtask

    initial begin
        rst = 1'b0; predReq = 1'b0; stall = 1'b0; predPC = '0; predCondMask = '0;
        clearUpd();
        repeat (3) step();
        check("rst_initBusy", initBusy, 1);
        check("rst_predValid", predValid, 0);
        check("rst_predTaken", predTaken, 0);
        check("rst_predCtr", predCtr, 0);
        check("rst_predHist", predHist, 0);

        // Requests and updates during INIT must be ignored
        rst = 1'b1; predReq = 1'b1; predPC = 32'h0; predCondMask = 2'b01;
        setUpd(0, 32'h100, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        cnt = 0;
        while (initBusy && cnt < 3000) begin step(); cnt++; end
        check("init_cycles", cnt, 1024);
        check("init_ignore_pred", predValid, 0);
        check("gas_init_done", initBusyG, 0);
        clearUpd();
        step();
        predReq = 1'b0;
        check("first_valid", predValid, 1);
        check("first_taken", predTaken, 2'b01);
        check("first_ctr", predCtr, 4'hA);
        check("first_hist", predHist, 0);
        step();
        check("valid_clear", predValid, 0);

        // Counter walks 2 -> 1 -> 0 and saturates; second update also restores set 0 history to 0
        setUpd(0, 32'h100, 4'h0, 2'd2, 1'b0, 1'b0, 1'b0); doUpd();
        setUpd(0, 32'h100, 4'h0, 2'd1, 1'b0, 1'b1, 1'b0); doUpd();
        doPred(32'h100, 2'b01);
        check("dec_taken", predTaken, 2'b00);
        check("dec_ctr", predCtr, 4'h8);
        check("dec_hist", predHist, 0);
        setUpd(0, 32'h100, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0); doUpd();
        doPred(32'h100, 2'b01);
        check("sat_low_hold", predCtr, 4'h8);
        setUpd(0, 32'h100, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0);
        doPred(32'h100, 2'b01);
        check("rdw_old", predCtr, 4'h8);
        doPred(32'h100, 2'b01);
        check("rdw_new", predCtr, 4'h9);
        setUpd(0, 32'h100, 4'h0, 2'd2, 1'b1, 1'b0, 1'b0);
        setUpd(1, 32'h100, 4'h0, 2'd1, 1'b0, 1'b0, 1'b0);
        doUpd();
        doPred(32'h100, 2'b01);
        check("port_prio", predCtr, 4'h8);
        setUpd(0, 32'h108, 4'h0, 2'd3, 1'b1, 1'b0, 1'b0); doUpd();
        doPred(32'h108, 2'b01);
        check("sat_high", predCtr, 4'hB);
        check("sat_high_taken", predTaken, 2'b01);

        // Two conditional slots, both weakly taken: only one shift
        setUpd(0, 32'h3C0, 4'h0, 2'd2, 1'b0, 1'b1, 1'b0); doUpd();
        doPred(32'h010, 2'b11);
        check("two_slot_taken", predTaken, 2'b01);
        check("two_slot_ctr", predCtr, 4'hA);
        doPred(32'h010, 2'b00);
        check("one_shift", predHist, 4'b0001);

        // Per-set vs. global history
        setUpd(0, 32'h000, 4'h0, 2'd2, 1'b1, 1'b1, 1'b0); doUpd();
        doPred(32'h000, 2'b01);
        check("set0_taken", predTaken, 2'b01);
        doPred(32'h400, 2'b01);
        check("set1_hist_indep", predHist, 4'b0000);
        check("gas_hist_shared", predHistG, 4'b0001);
        check("gas_taken", predTakenG, 2'b01);
        doPred(32'h000, 2'b00);
        check("sas_set0", predHist, 4'b0001);
        check("gas_shared", predHistG, 4'b0011);
        doPred(32'h400, 2'b00);
        check("sas_set1", predHist, 4'b0001);

        // Dual mispredict on set 0 with a same-cycle set-0 request
        setUpd(0, 32'h000, 4'b1010, 2'd2, 1'b1, 1'b1, 1'b1);
        setUpd(1, 32'h000, 4'b0110, 2'd2, 1'b0, 1'b1, 1'b1);
        doPred(32'h000, 2'b01);
        doPred(32'h000, 2'b00);
        check("recover_lowest", predHist, 4'b0101);
        setUpd(0, 32'h000, 4'h0, 2'd3, 1'b1, 1'b1, 1'b0);
        doPred(32'h400, 2'b01);
        doPred(32'h400, 2'b00);
        check("other_set_upd", predHist, 4'b0011);
        doPred(32'h000, 2'b00);
        check("recover_set0", predHist, 4'b0000);

        // Stall freezes outputs and speculative history
        doPred(32'h000, 2'b01);
        stall = 1'b1; predReq = 1'b1; predPC = 32'h400; predCondMask = 2'b01;
        step();
        check("stall_valid", predValid, 1);
        check("stall_hold_hist", predHist, 4'b0000);
        check("stall_hold_taken", predTaken, 2'b01);
        stall = 1'b0; predReq = 1'b0;
        step();
        check("valid_clear2", predValid, 0);
        doPred(32'h000, 2'b00);
        check("stall_no_shift", predHist, 4'b0001);
        doPred(32'h400, 2'b00);
        check("stall_set1", predHist, 4'b0011);
        doPred(32'h000, 2'b01);
        check("pre_rst_taken", predTaken, 2'b01);

        // Asynchronous reset in READY, then again mid-INIT
        #2 rst = 1'b0;
        #1;
        check("arst_valid", predValid, 0);
        check("arst_taken", predTaken, 0);
        check("arst_ctr", predCtr, 0);
        check("arst_hist", predHist, 0);
        check("arst_busy", initBusy, 1);
        step();
        rst = 1'b1;
        repeat (500) step();
        check("init_mid", initBusy, 1);
        #2 rst = 1'b0;
        #1;
        check("arst2_busy", initBusy, 1);
        step();
        rst = 1'b1;
        cnt = 0;
        while (initBusy && cnt < 3000) begin step(); cnt++; end
        check("reinit_cycles", cnt, 1024);
        doPred(32'h000, 2'b00);
        check("hist_cleared", predHist, 0);
        check("pht_reinit", predCtr, 4'hA);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
